ysyx_23060077_ifu_fq: RTL and testbench
=======================================

Name: ysyx_23060077_ifu_fq

Overview:
- Parametrised, prefetching instruction fetch unit; successor to the single-request IFU.
- Keeps up to MAX_OUTST in-order I-cache requests in flight and buffers returned instructions in a FQ_DEPTH-entry fetch queue ahead of IDU.
- On redirect (jump/branch/trap from EXU) it flushes the queue and discards stale in-flight responses.
- Pulses a fence.i indication to the I-cache when a fence.i leaves the queue.

Parameters:
- XLEN, 32, PC/instruction width.
- RESET_PC, 32'h3000_0000, PC after reset.
- FQ_DEPTH, 4, fetch-queue entries; power of two, >=2.
- MAX_OUTST, 2, max accepted-but-unanswered I-cache requests; >=1.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- redirect_valid_i  in  1  redirect PC this cycle.
- redirect_pc_i  in  XLEN  redirect target.
- ic_req_valid_o  out  1  fetch request valid.
- ic_req_ready_i  in  1  I-cache accepts request.
- ic_req_addr_o  out  XLEN  fetch address.
- ic_resp_valid_i  in  1  response data valid; responses return in request order.
- ic_resp_data_i  in  XLEN  fetched instruction.
- if_to_id_valid_o  out  1  queue head valid to IDU.
- if_to_id_ready_i  in  1  IDU accepts.
- ifu_pc_o  out  XLEN  head PC.
- ifu_inst_o  out  XLEN  head instruction.
- fence_i_o  out  1  one-cycle pulse to I-cache.
- fq_count_o  out  $clog2(FQ_DEPTH)+1  entries in queue.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (reset==0 sampled at posedge clock).
- Reset values:
  - fetch_pc = RESET_PC; resp_pc = RESET_PC.
  - outstanding = 0; drop_cnt = 0; queue empty.
  - fence_i_o = 0; ic_req_valid_o = 0 while reset is low.
  - if_to_id_valid_o = 0; ifu_pc_o and ifu_inst_o show the head entry (don't-care while invalid).
- State:
  - fetch_pc: next address to request.
  - resp_pc: PC of next non-dropped response.
  - outstanding: 0..MAX_OUTST.
  - drop_cnt: 0..MAX_OUTST.
  - FQ: circular buffer of {pc, inst} with head/tail pointers and count; pointers wrap modulo FQ_DEPTH.
- Request issue:
  - ic_req_valid_o = !redirect_valid_i && outstanding < MAX_OUTST && (outstanding - drop_cnt + count) < FQ_DEPTH. This credit rule guarantees every live response has a free slot.
  - ic_req_addr_o = fetch_pc.
  - On valid && ready: fetch_pc += 4 and outstanding increments. Wrap-around at 2^XLEN is natural modulo.
  - Request and response in the same cycle: outstanding is unchanged.
- Response handling (ic_resp_valid_i):
  - outstanding decrements.
  - If drop_cnt != 0: drop_cnt decrements and data is discarded.
  - Otherwise enqueue {resp_pc, ic_resp_data_i} at tail and resp_pc += 4.
  - Response with outstanding == 0 is illegal (assertion).
- Dequeue:
  - if_to_id_valid_o = (count != 0) && !redirect_valid_i.
  - Handshake when valid && ready: head advances.
  - Enqueue and dequeue in the same cycle: count unchanged. Full and empty are distinguished by count, not pointers.
- Redirect (has priority over everything):
  - fetch_pc <= redirect_pc_i; resp_pc <= redirect_pc_i.
  - Queue flushed: count = 0, head = tail.
  - No request is issued this cycle.
  - drop_cnt <= outstanding - (ic_resp_valid_i ? 1 : 0). The response arriving in the redirect cycle is itself discarded.
  - First new request issues the following cycle, with address redirect_pc_i.
  - Back-to-back redirects: the last one wins and drop_cnt is recomputed each time.
- fence.i:
  - When a dequeued inst has opcode 7'b0001111 and funct3 == 3'b001, fence_i_o = 1 in the next cycle, for one cycle.
  - The IFU keeps fetching; EXU is responsible for redirecting to pc+4.
- Reset mid-operation: all state returns to reset values on the next edge. Responses to pre-reset requests are a system-level violation (I-cache is reset concurrently).
- Latency: request accepted at cycle t, response at t+k → if_to_id_valid_o at t+k+1 (queue registered, no bypass).

Test Plan:
1. Reset release, ready=1, 1-cycle response latency, IDU always ready → requests 0x3000_0000, _0004, _0008… with no bubbles after pipeline fill; ifu_pc_o follows in order.
2. IDU ready=0 with FQ_DEPTH=4, MAX_OUTST=2 → exactly 4 entries fill (fq_count_o=4); ic_req_valid_o drops once outstanding+count reaches 4; raising ready drains 0x3000_0000.._000C in order.
3. Two requests outstanding, redirect to 0x8000_0100 → queue empties, next 2 responses discarded (drop_cnt 2→0), first delivered entry is pc=0x8000_0100 with its own data.
4. Redirect in the same cycle as a response with outstanding=1 → that response is dropped, drop_cnt=0, if_to_id_valid_o=0 in the redirect cycle.
5. Dequeue of 0x0000100F → fence_i_o high for exactly one cycle after the handshake; dequeue of 0x0000000F (fence) → no pulse.
6. reset driven low for 1 cycle mid-stream with a full queue → fq_count_o=0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ysyx_23060077_ifu_fq.sv
// Prefetching instruction fetch unit with an in-order I-cache request
// window and a small fetch queue ahead of the decoder.
module ysyx_23060077_ifu_fq #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(32'h3000_0000),
    parameter int               FQ_DEPTH  = 4,
    parameter int               MAX_OUTST = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      redirect_valid_i,
    input  logic [XLEN-1:0]           redirect_pc_i,
    output logic                      ic_req_valid_o,
    input  logic                      ic_req_ready_i,
    output logic [XLEN-1:0]           ic_req_addr_o,
    input  logic                      ic_resp_valid_i,
    input  logic [XLEN-1:0]           ic_resp_data_i,
    output logic                      if_to_id_valid_o,
    input  logic                      if_to_id_ready_i,
    output logic [XLEN-1:0]           ifu_pc_o,
    output logic [XLEN-1:0]           ifu_inst_o,
    output logic                      fence_i_o,
    output logic [$clog2(FQ_DEPTH):0] fq_count_o
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam logic [31:0] FQ_LIM  = FQ_DEPTH;
    localparam logic [31:0] OUT_LIM = MAX_OUTST;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   drop_cnt;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic            fence_q;

    logic [XLEN-1:0] pc_mem   [FQ_DEPTH];
    logic [XLEN-1:0] inst_mem [FQ_DEPTH];

    logic            req_fire;
    logic            deq_fire;
    logic            enq;
    logic            resp_drop;
    logic            head_fence_i;
    logic [31:0]     live;
    logic [XLEN-1:0] head_inst;

    // Issue credit, handshakes and queue head view
    always_comb begin
        live = 32'(outstanding) - 32'(drop_cnt) + 32'(count);
        ic_req_valid_o = reset
                       && !redirect_valid_i
                       && (32'(outstanding) < OUT_LIM)
                       && (live < FQ_LIM);
        ic_req_addr_o = fetch_pc;
        if_to_id_valid_o = (count != '0) && !redirect_valid_i;
        req_fire = ic_req_valid_o && ic_req_ready_i;
        deq_fire = if_to_id_valid_o && if_to_id_ready_i;
        resp_drop = ic_resp_valid_i && (drop_cnt != '0);
        enq = reset && ic_resp_valid_i
            && (drop_cnt == '0) && !redirect_valid_i;
        head_inst = inst_mem[head];
        ifu_pc_o = pc_mem[head];
        ifu_inst_o = head_inst;
        head_fence_i = (head_inst[6:0] == 7'b0001111)
                     && (head_inst[14:12] == 3'b001);
        fence_i_o = fence_q;
        fq_count_o = count;
    end

    // Fetch state, request window and queue pointers
    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            fence_q     <= 1'b0;
        end else if (redirect_valid_i) begin
            fetch_pc    <= redirect_pc_i;
            resp_pc     <= redirect_pc_i;
            outstanding <= outstanding - OW'(ic_resp_valid_i);
            drop_cnt    <= outstanding - OW'(ic_resp_valid_i);
            head        <= tail;
            count       <= '0;
            fence_q     <= 1'b0;
        end else begin
            if (req_fire)
                fetch_pc <= fetch_pc + XLEN'(4);
            outstanding <= outstanding + OW'(req_fire)
                         - OW'(ic_resp_valid_i);
            if (resp_drop)
                drop_cnt <= drop_cnt - OW'(1);
            if (enq) begin
                resp_pc <= resp_pc + XLEN'(4);
                tail    <= tail + PW'(1);
            end
            if (deq_fire)
                head <= head + PW'(1);
            count   <= count + CW'(enq) - CW'(deq_fire);
            fence_q <= deq_fire && head_fence_i;
        end
    end

    // Queue storage, written at the tail on a live response
    always_ff @(posedge clock) begin
        if (enq) begin
            pc_mem[tail]   <= resp_pc;
            inst_mem[tail] <= ic_resp_data_i;
        end
    end

    // A response can only answer an accepted request
    always_ff @(posedge clock) begin
        if (reset && ic_resp_valid_i)
            assert (outstanding != '0);
    end

endmodule

// File: tb/tb_ysyx_23060077_ifu_fq.sv
// Scoreboard bench for the prefetching fetch unit: an I-cache model
// answers requests in order, a monitor checks every dequeued entry.
module tb_ysyx_23060077_ifu_fq;

    localparam logic [31:0] RST_PC = 32'h3000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        ic_req_valid_o;
    logic        ic_req_ready_i = 1'b1;
    logic [31:0] ic_req_addr_o;
    logic        ic_resp_valid_i = 1'b0;
    logic [31:0] ic_resp_data_i = '0;
    logic        if_to_id_valid_o;
    logic        if_to_id_ready_i = 1'b0;
    logic [31:0] ifu_pc_o;
    logic [31:0] ifu_inst_o;
    logic        fence_i_o;
    logic [2:0]  fq_count_o;

    ysyx_23060077_ifu_fq dut (
        .clock            (clock),
        .reset            (reset),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .ic_req_valid_o   (ic_req_valid_o),
        .ic_req_ready_i   (ic_req_ready_i),
        .ic_req_addr_o    (ic_req_addr_o),
        .ic_resp_valid_i  (ic_resp_valid_i),
        .ic_resp_data_i   (ic_resp_data_i),
        .if_to_id_valid_o (if_to_id_valid_o),
        .if_to_id_ready_i (if_to_id_ready_i),
        .ifu_pc_o         (ifu_pc_o),
        .ifu_inst_o       (ifu_inst_o),
        .fence_i_o        (fence_i_o),
        .fq_count_o       (fq_count_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          fence;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    exp_t sb[$];
    req_t pend[$];
    int   checks = 0;
    int   failures = 0;
    int   lat = 1;
    int   cyc = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        case (a)
            32'h9000_0004: return 32'h0000_100F;
            32'h9000_000C: return 32'h0000_000F;
            default:       return a ^ 32'hFFFF_0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst,
                        input bit fence);
        exp_t e;
        e.pc = pc;
        e.inst = inst;
        e.fence = fence;
        sb.push_back(e);
    endtask

    // Each cycle: +1 responses, +2 stimulus, +3 monitor, +4 request capture
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            #2;
        end
    endtask

    task automatic reset_dut();
        if_to_id_ready_i = 1'b0;
        redirect_valid_i = 1'b0;
        reset = 1'b0;
        sb.delete();
        step(2);
        reset = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        if_to_id_ready_i = 1'b0;
        check(name, sb.size(), 0);
    endtask

    // I-cache model: in-order responses after lat cycles
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            #1;
            if (!reset) begin
                pend.delete();
                ic_resp_valid_i = 1'b0;
            end else if (pend.size() != 0 && pend[0].due <= cyc) begin
                ic_resp_valid_i = 1'b1;
                ic_resp_data_i = inst_of(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                ic_resp_valid_i = 1'b0;
                ic_resp_data_i = '0;
            end
            #3;
            if (reset && ic_req_valid_o && ic_req_ready_i)
                pend.push_back('{ic_req_addr_o, cyc + lat});
        end
    end

    // Monitor: pops the scoreboard on each IDU handshake
    initial begin
        bit   fence_exp;
        exp_t e;
        fence_exp = 1'b0;
        forever begin
            @(negedge clock);
            #3;
            if (!reset) begin
                fence_exp = 1'b0;
            end else begin
                check("fence_pulse", fence_i_o, fence_exp);
                fence_exp = 1'b0;
                if (if_to_id_valid_o && if_to_id_ready_i) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_deq actual=%h required=none",
                                 ifu_pc_o);
                    end else begin
                        e = sb.pop_front();
                        check("deq_pc", ifu_pc_o, e.pc);
                        check("deq_inst", ifu_inst_o, e.inst);
                        fence_exp = e.fence;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        step(3);
        check("rst_req_valid", ic_req_valid_o, 0);
        check("rst_id_valid", if_to_id_valid_o, 0);
        check("rst_count", fq_count_o, 0);
        check("rst_fence", fence_i_o, 0);

        // streaming, 1-cycle latency, IDU always ready
        lat = 1;
        reset = 1'b1;
        if_to_id_ready_i = 1'b1;
        for (int i = 0; i < 8; i++)
            push(RST_PC + 32'(4 * i), (RST_PC + 32'(4 * i)) ^ 32'hFFFF_0000, 0);
        step(1);
        check("t1_first_empty", if_to_id_valid_o, 0);
        step(1);
        for (int i = 0; i < 6; i++) begin
            check("t1_nobubble_id", if_to_id_valid_o, 1);
            check("t1_nobubble_req", ic_req_valid_o, 1);
            step(1);
        end
        drain("t1_drain", 20);

        // fill the queue with IDU stalled, then drain
        reset_dut();
        lat = 1;
        for (int i = 0; i < 4; i++)
            push(RST_PC + 32'(4 * i), (RST_PC + 32'(4 * i)) ^ 32'hFFFF_0000, 0);
        step(6);
        check("t2_full_count", fq_count_o, 4);
        check("t2_req_stop", ic_req_valid_o, 0);
        check("t2_head_valid", if_to_id_valid_o, 1);
        if_to_id_ready_i = 1'b1;
        drain("t2_drain", 20);

        // redirect with two requests in flight
        reset_dut();
        lat = 3;
        step(2);
        check("t3_window_full", ic_req_valid_o, 0);
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h8000_0100;
        step(1);
        redirect_valid_i = 1'b0;
        check("t3_flushed", fq_count_o, 0);
        if_to_id_ready_i = 1'b1;
        push(32'h8000_0100, 32'h7FFF_0100, 0);
        push(32'h8000_0104, 32'h7FFF_0104, 0);
        drain("t3_drain", 30);

        // redirect coinciding with a response, queue holding two entries
        reset_dut();
        lat = 1;
        step(3);
        check("t4_pre_count", fq_count_o, 2);
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h8000_0200;
        #1;
        check("t4_id_valid_redir", if_to_id_valid_o, 0);
        check("t4_req_valid_redir", ic_req_valid_o, 0);
        step(1);
        redirect_valid_i = 1'b0;
        #1;
        check("t4_flushed", fq_count_o, 0);
        check("t4_req_addr", ic_req_addr_o, 32'h8000_0200);
        check("t4_req_valid", ic_req_valid_o, 1);
        if_to_id_ready_i = 1'b1;
        push(32'h8000_0200, 32'h7FFF_0200, 0);
        push(32'h8000_0204, 32'h7FFF_0204, 0);
        drain("t4_drain", 20);

        // fence.i pulses once, plain fence does not
        reset_dut();
        lat = 1;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h9000_0000;
        if_to_id_ready_i = 1'b1;
        step(1);
        redirect_valid_i = 1'b0;
        push(32'h9000_0000, 32'h6FFF_0000, 0);
        push(32'h9000_0004, 32'h0000_100F, 1);
        push(32'h9000_0008, 32'h6FFF_0008, 0);
        push(32'h9000_000C, 32'h0000_000F, 0);
        push(32'h9000_0010, 32'h6FFF_0010, 0);
        drain("t5_drain", 20);
        step(2);

        // one-cycle reset with a full queue
        reset_dut();
        lat = 1;
        step(6);
        check("t6_full_count", fq_count_o, 4);
        reset = 1'b0;
        step(1);
        check("t6_count", fq_count_o, 0);
        check("t6_id_valid", if_to_id_valid_o, 0);
        check("t6_req_valid_low", ic_req_valid_o, 0);
        check("t6_fence", fence_i_o, 0);
        reset = 1'b1;
        #1;
        check("t6_req_valid", ic_req_valid_o, 1);
        check("t6_req_addr", ic_req_addr_o, RST_PC);
        push(RST_PC, RST_PC ^ 32'hFFFF_0000, 0);
        push(RST_PC + 32'd4, (RST_PC + 32'd4) ^ 32'hFFFF_0000, 0);
        if_to_id_ready_i = 1'b1;
        drain("t6_drain", 20);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
